// File: rtl/g11620_pix_accum.sv
// g11620_pix_accum: accumulates cap_num ADC bursts per pixel into a RAM, then streams the
// per-pixel sums over valid/ready.
module g11620_pix_accum #(
  parameter int PIX_NUM = 512,
  parameter int ADC_W = 16,
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_in,
  input  logic             soft_reset_in,
  input  logic [7:0]       cap_num_in,
  input  logic             ad_sp,
  input  logic [ADC_W-1:0] adc_data,
  output logic [ACC_W-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic             busy_o,
  output logic             done_o,
  output logic             ovf_o
);
  localparam int AW = $clog2(PIX_NUM);
  localparam logic [AW-1:0] LAST = AW'(PIX_NUM - 1);
  typedef enum logic [2:0] {IDLE, WAIT_SP, CAPTURE, DRAIN, DONE} state_t;
  state_t state;
  logic start_q, start_edge, last_pix, pop, out_free, issue;
  logic [7:0] cap_num, burst_cnt;
  logic [AW-1:0] pix, rd_ptr, rd_addr;
  logic [ACC_W-1:0] mem [PIX_NUM];
  logic [ACC_W-1:0] rd_data, acc_in, wr_data, skid_data;
  logic [ACC_W:0] sum;
  logic rd_pend, rd_pend_last, rd_all, skid_v, skid_last;
  logic [1:0] occ;
  assign start_edge = start_in & ~start_q;
  assign last_pix = pix == LAST;
  assign acc_in = burst_cnt == 8'd0 ? '0 : rd_data;
  assign sum = (ACC_W+1)'(adc_data) + (ACC_W+1)'(acc_in);
  assign wr_data = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
  assign pop = m_valid & m_ready;
  assign out_free = ~m_valid | m_ready;
  // words held or in flight after this cycle's pop; two slots (output + skid) keep drain bubble-free
  assign occ = 2'(m_valid) + 2'(skid_v) + 2'(rd_pend) - 2'(pop);
  assign issue = state == DRAIN && !rd_all && occ < 2'd2;
  // during capture, prefetch the next pixel so each cycle is one read-modify-write
  assign rd_addr = state == CAPTURE ? pix + 1'b1 : state == DRAIN ? rd_ptr : '0;
  always_ff @(posedge clk) begin
    if (state == CAPTURE) mem[pix] <= wr_data;
    rd_data <= mem[rd_addr];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      start_q <= 1'b0;
      cap_num <= '0;
      burst_cnt <= '0;
      pix <= '0;
      rd_ptr <= '0;
      rd_all <= 1'b0;
      rd_pend <= 1'b0;
      rd_pend_last <= 1'b0;
      skid_v <= 1'b0;
      skid_last <= 1'b0;
      skid_data <= '0;
      m_data <= '0;
      m_valid <= 1'b0;
      m_last <= 1'b0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      ovf_o <= 1'b0;
    end else begin
      start_q <= start_in;
      done_o <= 1'b0;
      if (soft_reset_in) begin
        state <= IDLE;
        m_valid <= 1'b0;
        m_last <= 1'b0;
        busy_o <= 1'b0;
        rd_pend <= 1'b0;
        skid_v <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start_edge) begin
            cap_num <= cap_num_in == 8'd0 ? 8'd1 : cap_num_in;
            ovf_o <= 1'b0;
            burst_cnt <= '0;
            pix <= '0;
            busy_o <= 1'b1;
            state <= WAIT_SP;
          end
          WAIT_SP: begin
            pix <= '0;
            if (ad_sp) state <= CAPTURE;
          end
          CAPTURE: begin
            pix <= pix + 1'b1;
            if (sum[ACC_W]) ovf_o <= 1'b1;
            if (last_pix && burst_cnt == cap_num - 8'd1) begin
              state <= DRAIN;
              rd_ptr <= '0;
              rd_all <= 1'b0;
              rd_pend <= 1'b0;
              skid_v <= 1'b0;
            end else if (last_pix) begin
              burst_cnt <= burst_cnt + 8'd1;
              state <= WAIT_SP;
            end
          end
          DRAIN: begin
            rd_pend <= issue;
            rd_pend_last <= rd_ptr == LAST;
            if (issue) rd_ptr <= rd_ptr + 1'b1;
            if (issue && rd_ptr == LAST) rd_all <= 1'b1;
            if (out_free) begin
              m_valid <= skid_v | rd_pend;
              if (skid_v | rd_pend) begin
                m_data <= skid_v ? skid_data : rd_data;
                m_last <= skid_v ? skid_last : rd_pend_last;
              end
              if (skid_v) begin
                skid_v <= rd_pend;
                skid_data <= rd_data;
                skid_last <= rd_pend_last;
              end
            end else if (rd_pend) begin
              skid_v <= 1'b1;
              skid_data <= rd_data;
              skid_last <= rd_pend_last;
            end
            if (pop && m_last) begin
              m_valid <= 1'b0;
              m_last <= 1'b0;
              done_o <= 1'b1;
              state <= DONE;
            end
          end
          DONE: begin
            busy_o <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_g11620_pix_accum.sv
// tb_g11620_pix_accum: scoreboard bench driving a 24-bit and a saturating 17-bit instance in lockstep.
module tb_g11620_pix_accum;
  localparam int PN = 512;
  logic clk = 0, rst_n = 0, start_in = 0, soft_reset_in = 0, ad_sp = 0, m_ready = 1;
  logic [7:0] cap_num_in = 0;
  logic [15:0] adc_data = 0;
  logic [23:0] m_data;
  logic m_valid, m_last, busy_o, done_o, ovf_o;
  logic [16:0] s_data;
  logic s_valid, s_last, s_busy, s_done, s_ovf;
  int vectors = 0, errors = 0, done_cnt = 0;
  bit rand_ready = 0;
  logic [23:0] q24[$];
  logic [16:0] q17[$];
  int qi[$];
  g11620_pix_accum #(.PIX_NUM(PN), .ADC_W(16), .ACC_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .start_in(start_in), .soft_reset_in(soft_reset_in),
    .cap_num_in(cap_num_in), .ad_sp(ad_sp), .adc_data(adc_data), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .busy_o(busy_o),
    .done_o(done_o), .ovf_o(ovf_o)
  );
  g11620_pix_accum #(.PIX_NUM(PN), .ADC_W(16), .ACC_W(17)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start_in(start_in), .soft_reset_in(soft_reset_in),
    .cap_num_in(cap_num_in), .ad_sp(ad_sp), .adc_data(adc_data), .m_data(s_data),
    .m_valid(s_valid), .m_ready(m_ready), .m_last(s_last), .busy_o(s_busy),
    .done_o(s_done), .ovf_o(s_ovf)
  );
  initial forever #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial forever begin
    @(posedge clk);
    #1 m_ready = rand_ready ? ($urandom_range(0, 99) < 40) : 1'b1;
  end
  // output monitor: hold stability while stalled, scoreboard pop on every handshake
  initial begin
    bit hold;
    logic [23:0] h_data;
    logic h_last;
    int idx;
    hold = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) hold = 0;
      else begin
        if (done_o) done_cnt++;
        if (hold) check("hold", 32'({m_valid, m_last, m_data}), 32'({1'b1, h_last, h_data}));
        hold = m_valid & ~m_ready;
        h_last = m_last;
        h_data = m_data;
        if (m_valid && m_ready) begin
          if (qi.size() == 0) check("spurious_valid", 32'(m_valid), 0);
          else begin
            idx = qi.pop_front();
            check("data24", 32'(m_data), 32'(q24.pop_front()));
            check("data17", 32'(s_data), 32'(q17.pop_front()));
            check("last24", 32'(m_last), 32'(idx == PN - 1));
            check("last17", 32'(s_last), 32'(idx == PN - 1));
          end
        end
      end
    end
  end
  task automatic run_frame(input int cap, input int kind, input int abort_b, input bit poke,
                           input bit rst_mid);
    int acc[PN];
    int nb, v, n, d0;
    bit o24, o17;
    nb = cap == 0 ? 1 : cap;
    foreach (acc[i]) acc[i] = 0;
    d0 = done_cnt;
    @(posedge clk);
    #1 cap_num_in = 8'(cap);
    start_in = 1;
    @(posedge clk);
    #1 start_in = 0;
    check("busy_start", 32'(busy_o), 1);
    check("ovf_clr", 32'(s_ovf), 0);
    for (int b = 0; b < nb; b++) begin
      ad_sp = 1;
      for (int i = 0; i < PN; i++) begin
        @(posedge clk);
        #1 ad_sp = poke && i == 100;
        start_in = poke && i >= 50 && i < 60;
        v = kind == 0 ? i : kind == 1 ? 'h1000 : kind == 2 ? 'hFFFF : int'($urandom_range(0, 65535));
        adc_data = 16'(v);
        acc[i] += v;
        if (b == abort_b && i == 200) begin
          soft_reset_in = 1;
          @(posedge clk);
          #1 soft_reset_in = 0;
          check("abort_busy", 32'(busy_o), 0);
          check("abort_valid", 32'(m_valid), 0);
          check("abort_done", 32'(done_o), 0);
          return;
        end
      end
      @(posedge clk);
      #1;
    end
    o24 = 0;
    o17 = 0;
    for (int i = 0; i < PN; i++) begin
      q24.push_back(24'(acc[i] > 'hFFFFFF ? 'hFFFFFF : acc[i]));
      q17.push_back(17'(acc[i] > 'h1FFFF ? 'h1FFFF : acc[i]));
      qi.push_back(i);
      o24 |= acc[i] > 'hFFFFFF;
      o17 |= acc[i] > 'h1FFFF;
    end
    n = 0;
    while (!done_o && n < 5000) begin
      @(posedge clk);
      #1 n++;
      if (rst_mid && n == 60) begin
        check("pre_rst_valid", 32'(m_valid), 1);
        #2 rst_n = 0;
        #1 check("rst_async", 32'({m_valid, m_last, busy_o, done_o, ovf_o}), 0);
        check("rst_data", 32'(m_data), 0);
        q24.delete();
        q17.delete();
        qi.delete();
        #10 rst_n = 1;
        return;
      end
    end
    check("done_seen", 32'(done_o), 1);
    if (!rand_ready) check("thruput", 32'(n <= 514), 1);
    check("ovf24", 32'(ovf_o), 32'(o24));
    check("ovf17", 32'(s_ovf), 32'(o17));
    @(posedge clk);
    #1 check("done_pulse", 32'(done_o), 0);
    check("busy_end", 32'(busy_o), 0);
    check("done_count", 32'(done_cnt - d0), 1);
    check("drained", 32'(qi.size()), 0);
  endtask
  initial begin
    int d0;
    repeat (2) @(posedge clk);
    #1 check("rst_outs", 32'({m_valid, m_last, busy_o, done_o, ovf_o, s_valid}), 0);
    check("rst_data", 32'(m_data), 0);
    rst_n = 1;
    run_frame(1, 0, -1, 0, 0);
    run_frame(4, 1, -1, 0, 0);
    run_frame(0, 1, -1, 0, 0);
    run_frame(3, 2, -1, 0, 0);
    repeat (10) @(posedge clk);
    #1 check("ovf_sticky", 32'(s_ovf), 1);
    rand_ready = 1;
    run_frame(2, 3, -1, 0, 0);
    rand_ready = 0;
    d0 = done_cnt;
    run_frame(4, 1, 2, 0, 0);
    repeat (30) @(posedge clk);
    #1 check("abort_no_done", 32'(done_cnt - d0), 0);
    check("abort_idle", 32'(busy_o), 0);
    run_frame(2, 0, -1, 1, 0);
    run_frame(1, 3, -1, 0, 1);
    run_frame(1, 0, -1, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/g11620_pix_accum.md
Name: g11620_pix_accum

Overview:
- Downstream of the G11620 sequencer.
- Captures the PIX_NUM-sample ADC burst that follows each ad_sp pulse and accumulates cap_num_in consecutive bursts per pixel into an internal accumulation RAM.
- Then streams the per-pixel sums out over a valid/ready interface to the host packetiser.
- Runs on the same clock as the sensor sequencer; the ADC sample for pixel i is valid on the i-th clk edge after ad_sp is sampled high.

Parameters:
PIX_NUM, 512, pixels per burst (power of two, 2..1024)
ADC_W, 16, ADC sample width
ACC_W, 24, accumulator/output width (ACC_W > ADC_W)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start_in  in  1  level; rising edge (registered compare) arms a new frame
soft_reset_in  in  1  synchronous abort to IDLE
cap_num_in  in  8  bursts to accumulate; 0 treated as 1; sampled on start edge
ad_sp  in  1  burst-start strobe from sensor
adc_data  in  ADC_W  ADC sample, one per clk during burst
m_data  out  ACC_W  pixel sum
m_valid  out  1  m_data valid
m_ready  in  1  consumer ready
m_last  out  1  high with final pixel (index PIX_NUM-1)
busy_o  out  1  high in every state except IDLE
done_o  out  1  one-cycle pulse after final output handshake
ovf_o  out  1  sticky; set if any sum saturated; cleared on next accepted start

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. RAM contents undefined, never read before first write.
- States:
  - IDLE: on start_in rising edge, latch cap_num (0 becomes 1), clear ovf_o, burst_cnt=0, go WAIT_SP. start edges outside IDLE are ignored.
  - WAIT_SP: pixel index = 0; issue RAM read of address 0. On ad_sp=1 go CAPTURE.
  - CAPTURE: for exactly PIX_NUM cycles, sample adc_data at pixel index i (i = 0..PIX_NUM-1, cycle k after ad_sp seen gives i = k-1).
    - Burst 0: write zero-extended sample.
    - Later bursts: write RAM[i] + sample, saturating at 2^ACC_W-1; saturation sets ovf_o.
    - RAM is single-port write / synchronous 1-cycle read. Read of address i+1 is issued in the cycle sample i arrives, so one full-rate RMW per cycle with no stall.
    - ad_sp during CAPTURE is ignored.
    - After i = PIX_NUM-1: if burst_cnt == cap_num-1, go DRAIN; else burst_cnt++ and go WAIT_SP.
  - DRAIN: present RAM[j] for j = 0..PIX_NUM-1 with valid/ready semantics.
    - Once m_valid is high, m_data/m_last are held stable until m_valid & m_ready.
    - First m_valid at most 2 cycles after entering DRAIN.
    - Back-to-back handshakes sustain 1 word/cycle when m_ready stays high (prefetch register; no bubble).
    - m_last = 1 only with j = PIX_NUM-1. After that handshake go DONE.
  - DONE: done_o = 1 for one cycle, then IDLE.
- soft_reset_in in any state: next cycle state IDLE, m_valid=0, m_last=0, busy_o=0. done_o is not pulsed. ovf_o is held.
- Counters: pixel counter log2(PIX_NUM) bits, wraps only via state change. burst_cnt 8 bits.
- Width: sum computed ACC_W+1 bits; carry bit selects saturation.
- Throughput: no backpressure is applied to the ADC. The ADC stream is never stalled; m_ready only affects DRAIN.

Test Plan:
- Single capture: cap_num_in=1, start edge, ad_sp, adc_data = pixel index (0..511) -> 512 outputs with m_data = 0..511, m_last on index 511 only, done_o one pulse, busy_o low afterwards.
- Accumulate: cap_num_in=4, each burst adc_data=16'h1000 -> every m_data = 24'h004000, ovf_o=0. Same test with cap_num_in=0 -> m_data = 24'h001000 (single burst).
- Saturation: ACC_W=17, cap_num_in=3, adc_data=16'hFFFF -> every m_data = 17'h1FFFF, ovf_o=1 and held until next start edge, then 0.
- Backpressure: random m_ready (~40% duty) during DRAIN -> m_data/m_last stable while stalled, no dropped or duplicated pixels, sequence identical to m_ready=1 run. With m_ready=1, 512 handshakes complete in ≤514 cycles.
- Abort: soft_reset_in at pixel 200 of burst 2 (cap_num_in=4) -> IDLE next cycle, no m_valid, no done_o. A new start then yields correct sums with no stale data from the aborted frame.
- Protocol edges: start edge while busy and extra ad_sp mid-CAPTURE -> both ignored, output unchanged. Async rst_n asserted mid-DRAIN -> outputs 0 immediately, without waiting for a clock edge.
